// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction fetch (IF) and data load/store (DM) onto one memory port.
// Define MEM_ARB_RR_EN for round-robin on collisions; otherwise DM has fixed priority over IF.
module mem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWNER_IF, OWNER_DM} owner_t;

`ifdef MEM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    state_t        r_state, w_nextState;
    owner_t        r_owner, r_lastGrant;
    logic [3:0]    r_cnt;

    logic          r_ifAck, r_dmAck, r_memEn, r_memWe, r_busy;
    logic [DW-1:0] r_ifRdata, r_dmRdata, r_memWdata;
    logic [AW-1:0] r_memAddr;

    logic          w_anyReq, w_grantDm, w_cntZero;
    logic          w_memEnNext, w_memWeNext, w_ifAckNext, w_dmAckNext, w_busyNext;
    logic [AW-1:0] w_memAddrNext;
    logic [DW-1:0] w_memWdataNext;

    assign w_anyReq  = if_req | dm_req;
    assign w_cntZero = (r_cnt == 4'd0);
    // On a collision round-robin picks the port that was not granted last; RR_EN=0 folds this to DM-first.
    assign w_grantDm = dm_req & (~if_req | ~RR_EN | (r_lastGrant == OWNER_IF));

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_owner     <= OWNER_IF;
            r_lastGrant <= OWNER_IF;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_owner <= w_grantDm ? OWNER_DM : OWNER_IF;
                        r_cnt   <= 4'(WAIT_CYC - 1);
                    end
                end
                ACCESS: begin
                    if (!w_cntZero) r_cnt <= r_cnt - 4'd1;
                end
                RESP: r_lastGrant <= r_owner;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq) w_nextState = ACCESS;
            ACCESS:  if (w_cntZero) w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Next values of the registered outputs; the mem_* registers double as the latched request.
    always_comb begin
        w_memEnNext    = (w_nextState == ACCESS);
        w_memWeNext    = 1'b0;
        w_memAddrNext  = '0;
        w_memWdataNext = '0;
        if (w_nextState == ACCESS) begin
            if (r_state == IDLE) begin
                w_memWeNext    = w_grantDm & dm_we;
                w_memAddrNext  = w_grantDm ? dm_addr : if_addr;
                w_memWdataNext = w_grantDm ? dm_wdata : '0;
            end else begin
                w_memWeNext    = r_memWe;
                w_memAddrNext  = r_memAddr;
                w_memWdataNext = r_memWdata;
            end
        end
        w_ifAckNext = (r_state == ACCESS) && w_cntZero && (r_owner == OWNER_IF);
        w_dmAckNext = (r_state == ACCESS) && w_cntZero && (r_owner == OWNER_DM);
        w_busyNext  = (w_nextState != IDLE);
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_memEn    <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_ifAck    <= 1'b0;
            r_dmAck    <= 1'b0;
            r_busy     <= 1'b0;
            r_ifRdata  <= '0;
            r_dmRdata  <= '0;
        end else begin
            r_memEn    <= w_memEnNext;
            r_memWe    <= w_memWeNext;
            r_memAddr  <= w_memAddrNext;
            r_memWdata <= w_memWdataNext;
            r_ifAck    <= w_ifAckNext;
            r_dmAck    <= w_dmAckNext;
            r_busy     <= w_busyNext;
            if ((r_state == ACCESS) && w_cntZero && !r_memWe) begin
                if (r_owner == OWNER_IF) r_ifRdata <= mem_rdata;
                else                     r_dmRdata <= mem_rdata;
            end
        end
    end

    assign if_ack    = r_ifAck;
    assign if_rdata  = r_ifRdata;
    assign dm_ack    = r_dmAck;
    assign dm_rdata  = r_dmRdata;
    assign mem_en    = r_memEn;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a small memory model.
// Instance dut runs with WAIT_CYC=1, instance dutB with WAIT_CYC=3 for the wait-state case.
module tb_mem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int WC   = 1;
    localparam int WC_B = 3;

    logic          clk   = 1'b0;
    logic          rst_f = 1'b0;
    logic          ifReq, dmReq, dmWe;
    logic [AW-1:0] ifAddr, dmAddr;
    logic [DW-1:0] dmWdata;
    logic          ifAck, dmAck, memEn, memWe, busy;
    logic [DW-1:0] ifRdata, dmRdata, memWdata, memRdata;
    logic [AW-1:0] memAddr;

    logic          bIfReq;
    logic [AW-1:0] bIfAddr, bMemAddr;
    logic          bIfAck, bDmAck, bMemEn, bMemWe, bBusy;
    logic [DW-1:0] bIfRdata, bDmRdata, bMemWdata, bMemRdata;

    int passCount  = 0;
    int failCount  = 0;
    int totalCount = 0;

    typedef struct {
        bit            isDm;
        bit            isStore;
        logic [DW-1:0] data;
        int            lat;
    } expT;

    expT           sb[$];
    logic [DW-1:0] ifModel, dmModel;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(WC)) dut (
        .clk(clk), .rst_f(rst_f),
        .if_req(ifReq), .if_addr(ifAddr), .if_ack(ifAck), .if_rdata(ifRdata),
        .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
        .dm_ack(dmAck), .dm_rdata(dmRdata),
        .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .busy(busy)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(WC_B)) dutB (
        .clk(clk), .rst_f(rst_f),
        .if_req(bIfReq), .if_addr(bIfAddr), .if_ack(bIfAck), .if_rdata(bIfRdata),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0000), .dm_wdata(32'h0),
        .dm_ack(bDmAck), .dm_rdata(bDmRdata),
        .mem_en(bMemEn), .mem_we(bMemWe), .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
        .mem_rdata(bMemRdata), .busy(bBusy)
    );

    function automatic logic [DW-1:0] memPattern(input logic [AW-1:0] a);
        return (a == 16'h0004) ? 32'h12345678 : {16'hC0DE, a};
    endfunction

    // Memory model for dut: reloads its pattern on reset, writes on enabled store cycles.
    logic [DW-1:0] memA [0:255];
    always @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            for (int i = 0; i < 256; i++) memA[i] <= memPattern(16'(i));
        end else if (memEn && memWe) begin
            memA[memAddr[7:0]] <= memWdata;
        end
    end
    assign memRdata = memEn ? memA[memAddr[7:0]] : '0;

    // dutB's memory only presents good data in the last of its WAIT_CYC enabled cycles.
    int bEnCnt;
    always @(posedge clk or negedge rst_f) begin
        if (!rst_f) bEnCnt <= 0;
        else        bEnCnt <= bMemEn ? bEnCnt + 1 : 0;
    end
    assign bMemRdata = (bMemEn && bEnCnt == WC_B - 1) ? {16'hB000, bMemAddr} : 32'hBAD0BAD0;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit isDm, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] expData,
                                 input int expLat);
        expT e;
        if (isDm) begin
            dmReq   = 1'b1;
            dmWe    = we;
            dmAddr  = addr;
            dmWdata = wdata;
        end else begin
            ifReq  = 1'b1;
            ifAddr = addr;
        end
        e.isDm    = isDm;
        e.isStore = we;
        e.data    = expData;
        e.lat     = expLat;
        sb.push_back(e);
    endtask

    // Waits for the requested port's ack, drops its req, then checks against the scoreboard head.
    task automatic waitAck(input bit wantDm, input string tag);
        expT e;
        bit  seen, wrong, dual;
        int  lat, enC, weC;
        seen = 1'b0; wrong = 1'b0; dual = 1'b0;
        lat = 0; enC = 0; weC = 0;
        e.isDm = wantDm; e.isStore = 1'b0; e.data = '0; e.lat = -1;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (memEn) enC++;
            if (memWe) weC++;
            if (ifAck && dmAck) dual = 1'b1;
            if (wantDm ? ifAck : dmAck) wrong = 1'b1;
            if (wantDm ? dmAck : ifAck) begin
                seen = 1'b1;
                lat  = k;
                if (wantDm) dmReq = 1'b0;
                else        ifReq = 1'b0;
            end
        end
        checkOutput({tag, ".ackSeen"}, 32'(seen), 32'd1);
        if (sb.size() > 0) e = sb.pop_front();
        if (!e.isStore) begin
            if (e.isDm) dmModel = e.data;
            else        ifModel = e.data;
        end
        checkOutput({tag, ".latency"}, 32'(lat), 32'(e.lat));
        checkOutput({tag, ".memEnCycles"}, 32'(enC), 32'(WC));
        checkOutput({tag, ".memWeCycles"}, 32'(weC), e.isStore ? 32'(WC) : 32'd0);
        checkOutput({tag, ".ifRdata"}, ifRdata, ifModel);
        checkOutput({tag, ".dmRdata"}, dmRdata, dmModel);
        checkOutput({tag, ".otherAck"}, 32'(wrong), 32'd0);
        checkOutput({tag, ".dualAck"}, 32'(dual), 32'd0);
        @(negedge clk);
        checkOutput({tag, ".ackPulse"}, 32'(wantDm ? dmAck : ifAck), 32'd0);
        checkOutput({tag, ".busyIdle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit seen, wrong, ackInReset;
        int lat, enC, busyC;
        ifReq = 1'b0; dmReq = 1'b0; dmWe = 1'b0;
        ifAddr = '0; dmAddr = '0; dmWdata = '0;
        bIfReq = 1'b0; bIfAddr = '0;
        ifModel = '0; dmModel = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset.ifAck", 32'(ifAck), 32'd0);
        checkOutput("reset.dmAck", 32'(dmAck), 32'd0);
        checkOutput("reset.ifRdata", ifRdata, 32'd0);
        checkOutput("reset.dmRdata", dmRdata, 32'd0);
        checkOutput("reset.memEn", 32'(memEn), 32'd0);
        checkOutput("reset.memWe", 32'(memWe), 32'd0);
        checkOutput("reset.memAddr", 32'(memAddr), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.bBusy", 32'(bBusy), 32'd0);
        rst_f = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 1'b0, 16'h0004, '0, 32'h12345678, WC + 1);
        waitAck(1'b0, "fetch");

        applyStimulus(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, '0, WC + 1);
        waitAck(1'b1, "store");
        applyStimulus(1'b1, 1'b0, 16'h0010, '0, 32'hDEADBEEF, WC + 1);
        waitAck(1'b1, "load");

        // Collision; the previous grant was DM, so round-robin favours IF.
`ifdef MEM_ARB_RR_EN
        applyStimulus(1'b0, 1'b0, 16'h0020, '0, 32'hC0DE0020, WC + 1);
        applyStimulus(1'b1, 1'b0, 16'h0030, '0, 32'hC0DE0030, WC + 1);
        waitAck(1'b0, "collIf");
        waitAck(1'b1, "collDm");
`else
        applyStimulus(1'b1, 1'b0, 16'h0030, '0, 32'hC0DE0030, WC + 1);
        applyStimulus(1'b0, 1'b0, 16'h0020, '0, 32'hC0DE0020, WC + 1);
        waitAck(1'b1, "collDm");
        waitAck(1'b0, "collIf");
`endif

        applyStimulus(1'b0, 1'b0, 16'h0040, '0, 32'hC0DE0040, WC + 1);
        waitAck(1'b0, "b2b1");
        applyStimulus(1'b0, 1'b0, 16'h0044, '0, 32'hC0DE0044, WC + 1);
        waitAck(1'b0, "b2b2");

        // Reset in the middle of an access.
        ifReq  = 1'b1;
        ifAddr = 16'h0050;
        @(negedge clk);
        checkOutput("rstMid.memEnBefore", 32'(memEn), 32'd1);
        rst_f = 1'b0;
        ifModel = '0;
        dmModel = '0;
        #1;
        checkOutput("rstMid.memEn", 32'(memEn), 32'd0);
        checkOutput("rstMid.busy", 32'(busy), 32'd0);
        ackInReset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ifAck || dmAck) ackInReset = 1'b1;
        end
        checkOutput("rstMid.noAck", 32'(ackInReset), 32'd0);
        checkOutput("rstMid.ifRdata", ifRdata, 32'd0);
        checkOutput("rstMid.dmRdata", dmRdata, 32'd0);
        rst_f = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0050, '0, 32'hC0DE0050, WC + 1);
        waitAck(1'b0, "rstRetry");

        // Wait states on dutB.
        bIfReq  = 1'b1;
        bIfAddr = 16'h0060;
        seen = 1'b0; wrong = 1'b0; lat = 0; enC = 0; busyC = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (bMemEn) enC++;
            if (bBusy) busyC++;
            if (bDmAck) wrong = 1'b1;
            if (bIfAck) begin
                seen   = 1'b1;
                lat    = k;
                bIfReq = 1'b0;
            end
        end
        checkOutput("wait3.ackSeen", 32'(seen), 32'd1);
        checkOutput("wait3.latency", 32'(lat), 32'(WC_B + 1));
        checkOutput("wait3.memEnCycles", 32'(enC), 32'(WC_B));
        checkOutput("wait3.busyCycles", 32'(busyC), 32'(WC_B + 1));
        checkOutput("wait3.ifRdata", bIfRdata, 32'hB0000060);
        checkOutput("wait3.dmAck", 32'(wrong), 32'd0);
        @(negedge clk);
        checkOutput("wait3.ackPulse", 32'(bIfAck), 32'd0);
        checkOutput("wait3.busyIdle", 32'(bBusy), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
